uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Parametrised UART transmitter, successor to the fixed 8N1 transmitter.
//  Configurable data width, parity mode and stop-bit count. Words enter
//  through a valid/ready handshake into buffered storage, so frames go out
//  back-to-back with no idle gap. Sits between the console mux datapath and
//  the physical TX pin.
// PARAMETERS
//  DATA_BITS    8  data bits per frame, legal 5..9, sent LSB first
//  PARITY       0  0=none, 1=odd, 2=even (encodings in uart_pkg)
//  STOP_BITS    1  stop bits per frame, legal 1..2
//  CLK_PER_BIT  8  clk cycles per serial bit, >=2
//  FIFO_DEPTH   4  entries in the input FIFO, power of 2 and >=2; only used with UART_TX_FIFO_EN
// PORTS
//  clk         in   1                     system clock, all logic on posedge
//  rst         in   1                     asynchronous, active-high reset
//  data        in   DATA_BITS             word to transmit
//  data_valid  in   1                     data is valid this cycle
//  data_ready  out  1                     storage can accept a word; a transfer occurs on a clk edge with valid&&ready
//  busy        out  1                     frame in progress or storage non-empty
//  level       out  $clog2(FIFO_DEPTH)+1  words held in storage (0..1 without FIFO)
//  serial      out  1                     TX line, idle high, registered
// BEHAVIOUR
//  Reset (async): serial=1, busy=0, level=0, data_ready=0 while rst high.
//   Storage flushed, FSM->IDLE, counters 0. A reset mid-frame aborts it; the
//   line returns high at once.
//  After reset release, data_ready = !full (combinational from storage state).
//   There is no pass-through: a push into full storage is not taken, even if a
//   pop happens in the same cycle.
//  FSM states (codes in uart_pkg): IDLE, START, DATA, PARITY, STOP.
//   IDLE: serial=1. If storage is non-empty: pop into shift reg, go to START,
//    serial<=0. Latency: word accepted at edge E0 -> serial low from edge E1.
//   START: hold 0 for CLK_PER_BIT cycles -> DATA.
//   DATA: bit index 0..DATA_BITS-1, each bit held for CLK_PER_BIT cycles.
//    After the last bit: go to PARITY if PARITY!=0, else STOP.
//   PARITY: one bit time. odd: ^word ^ 1; even: ^word. Parity is computed
//    over the DATA_BITS data bits at load time.
//   STOP: serial=1 for STOP_BITS*CLK_PER_BIT cycles. At the end: if storage is
//    non-empty, pop and go directly to START (zero idle cycles); else IDLE.
//  Frame length = CLK_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles, exact.
//  Bit timer: width $clog2(CLK_PER_BIT), counts 0..CLK_PER_BIT-1 and wraps
//   at the bit boundary. Bit index width is 4 bits, which covers up to 9.
//  busy = (state!=IDLE) | (level!=0). It drops the cycle after the last stop
//   bit completes with empty storage.
//  Simultaneous push and pop: level holds its value. Pointers wrap mod FIFO_DEPTH.
//  Illegal parameters are rejected by an elaboration-time check ($error in an
//   initial/generate block).
// CONFIGURATION
//  UART_TX_FIFO_EN defined: storage is a FIFO_DEPTH-entry FIFO (uart_tx_fifo).
//   level ranges 0..FIFO_DEPTH.
//  Undefined: storage is a single holding register (double buffer with the
//   shift reg). level ranges 0..1; the upper bits of level are tied to 0.
//   FIFO_DEPTH is ignored.
// STRUCTURE
//  uart_pkg: FSM state localparams, PARITY_NONE/ODD/EVEN encodings, and a
//   parity function.
//  Sub-module uart_tx_fifo: sync FIFO with push/pop/full/empty/level and
//   async rst.
//  The top holds the FSM, bit timer, shift reg and parity bit.
// TESTING
//  1. 8N1, CLK_PER_BIT=8, push 0xA5 -> serial 0,1,0,1,0,0,1,0,1,1, each bit
//     held 8 clk; 80 clk total; busy low after.
//  2. DATA_BITS=7, PARITY=odd, STOP_BITS=2, push 0x03 -> data 1100000,
//     parity bit 1, then 2 stop bits; frame 11*8 clk.
//  3. PARITY=even, push 0x07 -> parity bit 1; push 0x03 -> parity bit 0.
//  4. Back-to-back: push 0x55 then 0xAA while the first frame is sending ->
//     second start bit begins on the cycle after the last stop bit.
//  5. FIFO_EN with depth 4: push 6 words with valid held -> data_ready=0
//     when level=4. All 6 words are sent in order and none are lost.
//  6. Assert rst in the middle of DATA -> serial=1 immediately, level=0,
//     busy=0. After release, push 0x3C -> a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the configurable UART transmitter:
//               FSM state codes, parity mode encodings and the parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Parity mode encodings used by the PARITY parameter
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Transmit FSM state codes
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Turns the XOR of all data bits into the transmitted parity bit.
    // Odd parity makes the total count of ones (data + parity) odd.
    function automatic logic parity_bit(input logic xor_all, input int mode);
        return (mode == PARITY_ODD) ? ~xor_all : xor_all;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous FIFO with first-word fall-through read data.
//               Pushes into a full FIFO and pops from an empty FIFO are
//               ignored. Asynchronous active-high reset.
// Ports       : clk, rst          - clock, async active-high reset
//               i_push, i_wdata   - write request and data
//               i_pop             - read request (o_rdata is the head word)
//               o_full, o_empty   - storage status
//               o_level           - number of words held (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (c_aw+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop  & ~o_empty;

    // Storage array carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : uart_tx_fifo
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : Parametrised UART transmitter (data width, parity, stop bits).
//               Words enter through a valid/ready handshake into buffered
//               storage so consecutive frames leave with no idle gap.
//               Build option UART_TX_FIFO_EN: storage is a FIFO_DEPTH-entry
//               FIFO; otherwise a single holding register.
// Ports       : clk        - system clock
//               rst        - asynchronous active-high reset
//               data       - word to transmit (DATA_BITS wide, LSB first)
//               data_valid - data valid this cycle
//               data_ready - storage can accept a word
//               busy       - frame in progress or storage non-empty
//               level      - words held in storage
//               serial     - registered TX line, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int CLK_PER_BIT = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          serial
);

    localparam int              c_tw         = $clog2(CLK_PER_BIT);
    localparam int              c_lw         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_tw-1:0] c_timer_max  = c_tw'(CLK_PER_BIT - 1);
    localparam logic [3:0]      c_last_data  = 4'(DATA_BITS - 1);
    localparam logic [3:0]      c_last_stop  = 4'(STOP_BITS - 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_chk_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1..2");
    end
    if (CLK_PER_BIT < 2) begin : g_chk_clk_per_bit
        $error("uart_tx_cfg: CLK_PER_BIT must be >= 2");
    end

    // ------------------------------------------------------------------
    // Input storage
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] w_pop_data;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    // Ready is a pure function of fullness: a same-cycle pop never frees
    // room for the incoming word.
    assign data_ready = ~rst & ~w_full;
    assign w_push     = data_valid & data_ready;

`ifdef UART_TX_FIFO_EN
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fifo_depth
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (data),
        .i_pop   (w_pop),
        .o_rdata (w_pop_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );
`else
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_valid;

    // Holding register: push only when empty, pop only when full, so the
    // two never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                r_hold_valid <= 1'b0;
            end
            if (w_push) begin
                r_hold       <= data;
                r_hold_valid <= 1'b1;
            end
        end
    end

    assign w_pop_data = r_hold;
    assign w_full     = r_hold_valid;
    assign w_empty    = ~r_hold_valid;
    assign level      = c_lw'(r_hold_valid);
`endif

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    uart_state_e          r_state;
    uart_state_e          w_state_next;
    logic [c_tw-1:0]      r_timer;
    logic [c_tw-1:0]      w_timer_next;
    logic [3:0]           r_idx;
    logic [3:0]           w_idx_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_parity;
    logic                 w_parity_next;
    logic                 r_serial;
    logic                 w_serial_next;
    logic                 w_bit_end;
    logic                 w_load;

    assign w_bit_end = (r_timer == c_timer_max);
    assign busy      = (r_state != ST_IDLE) | ~w_empty;
    assign serial    = r_serial;

    always_comb begin
        w_state_next  = r_state;
        w_timer_next  = r_timer;
        w_idx_next    = r_idx;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_serial_next = r_serial;
        w_load        = 1'b0;
        w_pop         = 1'b0;

        if (r_state != ST_IDLE) begin
            w_timer_next = w_bit_end ? '0 : r_timer + 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                w_serial_next = 1'b1;
                w_timer_next  = '0;
                w_load        = ~w_empty;
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next  = ST_DATA;
                    w_idx_next    = '0;
                    w_serial_next = r_shift[0];
                    w_shift_next  = r_shift >> 1;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == c_last_data) begin
                        w_idx_next = '0;
                        if (PARITY != PARITY_NONE) begin
                            w_state_next  = ST_PARITY;
                            w_serial_next = r_parity;
                        end else begin
                            w_state_next  = ST_STOP;
                            w_serial_next = 1'b1;
                        end
                    end else begin
                        w_idx_next    = r_idx + 4'd1;
                        w_serial_next = r_shift[0];
                        w_shift_next  = r_shift >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next  = ST_STOP;
                    w_idx_next    = '0;
                    w_serial_next = 1'b1;
                end
            end
            ST_STOP: begin
                w_serial_next = 1'b1;
                if (w_bit_end) begin
                    if (r_idx == c_last_stop) begin
                        // Chain straight into the next start bit when a word
                        // is waiting, otherwise fall back to idle.
                        if (!w_empty) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_idx_next = r_idx + 4'd1;
                    end
                end
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_serial_next = 1'b1;
                w_timer_next  = '0;
            end
        endcase

        // Pop the next word: parity is fixed at load time from the full word.
        if (w_load) begin
            w_pop         = 1'b1;
            w_state_next  = ST_START;
            w_shift_next  = w_pop_data;
            w_parity_next = parity_bit(^w_pop_data, PARITY);
            w_serial_next = 1'b0;
            w_timer_next  = '0;
            w_idx_next    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer  <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_serial <= 1'b1;
        end else begin
            r_timer  <= w_timer_next;
            r_idx    <= w_idx_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_serial <= w_serial_next;
        end
    end

endmodule : uart_tx_cfg
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Self-checking bench for uart_tx_cfg. Three configurations
//               run side by side (8N1/8clk, 7O2/8clk, 8E1/4clk), each shadowed
//               by a frame-level reference model; directed frame tables plus
//               reset, back-to-back, storage-depth and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    function automatic int db_of(input int g);
        return (g == 1) ? 7 : 8;
    endfunction
    function automatic int par_of(input int g);
        return g;               // 0 none, 1 odd, 2 even
    endfunction
    function automatic int sb_of(input int g);
        return (g == 1) ? 2 : 1;
    endfunction
    function automatic int cpb_of(input int g);
        return (g == 2) ? 4 : 8;
    endfunction

`ifdef UART_TX_FIFO_EN
    localparam int c_cap = 4;
`else
    localparam int c_cap = 1;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0][8:0] din;
    logic [2:0]      dv;
    logic [2:0]      ser;
    logic [2:0]      bsy;
    logic [2:0]      rdy;
    logic [2:0][2:0] lvl;

    // Reference model outputs, one bit/field per configuration
    logic [2:0]      e_ser;
    logic [2:0]      e_busy;
    logic [2:0]      e_room;
    logic [2:0]      e_took;
    logic [2:0][2:0] e_lvl;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int DB  = db_of(g);
        localparam int PAR = par_of(g);
        localparam int SB  = sb_of(g);
        localparam int CPB = cpb_of(g);

        uart_tx_cfg #(
            .DATA_BITS   (DB),
            .PARITY      (PAR),
            .STOP_BITS   (SB),
            .CLK_PER_BIT (CPB),
            .FIFO_DEPTH  (4)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .data       (din[g][DB-1:0]),
            .data_valid (dv[g]),
            .data_ready (rdy[g]),
            .busy       (bsy[g]),
            .level      (lvl[g]),
            .serial     (ser[g])
        );

        logic       m_ser  = 1'b1;
        logic       m_busy = 1'b0;
        logic       m_room = 1'b1;
        logic       m_took = 1'b0;
        logic [2:0] m_lvl  = 3'd0;

        assign e_ser[g]  = m_ser;
        assign e_busy[g] = m_busy;
        assign e_room[g] = m_room;
        assign e_took[g] = m_took;
        assign e_lvl[g]  = m_lvl;

        // Frame-level model: a queue of pending words and the bit list of the
        // frame on the line, indexed by cycles elapsed since its start.
        initial begin : model
            logic [8:0]  q[$];
            logic [15:0] fb;
            logic [8:0]  w;
            int          fpos, flen, pre, nb;
            bit          ending, do_pop, do_push;
            fpos = -1;
            flen = 1;
            fb   = '0;
            forever begin
                @(posedge clk or posedge rst);
                m_took = 1'b0;
                if (rst) begin
                    q.delete();
                    fpos = -1;
                end else begin
                    pre     = q.size();
                    ending  = (fpos == flen - 1);
                    do_push = dv[g] && (pre < c_cap);
                    do_pop  = (fpos < 0 || ending) && (pre > 0);
                    if (do_pop) begin
                        w     = q.pop_front();
                        fb    = '0;
                        fb[0] = 1'b0;
                        for (int i = 0; i < DB; i++) fb[1+i] = w[i];
                        nb = 1 + DB;
                        if (PAR != 0) begin
                            fb[nb] = (PAR == 1) ? ~(^w) : (^w);
                            nb++;
                        end
                        for (int i = 0; i < SB; i++) begin
                            fb[nb] = 1'b1;
                            nb++;
                        end
                        flen = nb * CPB;
                        fpos = 0;
                    end else if (fpos >= 0) begin
                        if (ending) fpos = -1;
                        else        fpos++;
                    end
                    if (do_push) begin
                        q.push_back(din[g] & 9'((1 << DB) - 1));
                        m_took = 1'b1;
                    end
                end
                m_ser  = (fpos < 0) ? 1'b1 : fb[fpos / CPB];
                m_busy = (fpos >= 0) || (q.size() != 0);
                m_lvl  = 3'(q.size());
                m_room = (q.size() < c_cap);
            end
        end
    end

    typedef struct {
        int         cfg;
        logic [8:0] word;
        logic [11:0] seq;    // line bits in transmit order, first at [nbits-1]
        int         nbits;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cfg%0d cycle %0d: got %0h expected %0h", name, g, cyc, act, exp);
        end
    endtask

    // Advance one clock; compare every configuration against its model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int g = 0; g < 3; g++) begin
            chk("serial", g, ser[g], e_ser[g]);
            chk("busy",   g, bsy[g], e_busy[g]);
            chk("level",  g, lvl[g], e_lvl[g]);
            chk("ready",  g, rdy[g], e_room[g] & ~rst);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (e_busy != 3'b000 && k < 5000) begin
            tick();
            k++;
        end
        for (int g = 0; g < 3; g++) chk("drain busy", g, bsy[g], 0);
    endtask

    // Push one word into an idle transmitter and sample each bit mid-cell,
    // then check the exact frame end.
    task automatic run_vec(input vec_t v);
        int c, cpb;
        c   = v.cfg;
        cpb = cpb_of(c);
        wait_idle();
        din[c] = v.word;
        dv[c]  = 1'b1;
        tick();                         // accepted at this edge (E0)
        dv[c]  = 1'b0;
        repeat (1 + cpb / 2) tick();    // middle of the start bit
        for (int i = 0; i < v.nbits; i++) begin
            if (i > 0) repeat (cpb) tick();
            chk("frame bit", c, ser[c], v.seq[v.nbits-1-i]);
        end
        repeat (cpb - cpb / 2 - 1) tick();
        chk("busy last cycle", c, bsy[c], 1);
        tick();
        chk("busy after frame", c, bsy[c], 0);
        chk("line idle", c, ser[c], 1);
    endtask

    initial begin
        int         k, e0, idx, maxl;
        logic [8:0] words [6];

        din = '0;
        dv  = '0;
        tbl[0] = '{0, 9'h03C, 12'b000001111001, 10};
        tbl[1] = '{0, 9'h0A5, 12'b000101001011, 10};
        tbl[2] = '{1, 9'h003, 12'b001100000111, 11};
        tbl[3] = '{2, 9'h007, 12'b001110000011, 11};
        tbl[4] = '{2, 9'h003, 12'b001100000001, 11};
        tbl[5] = '{1, 9'h055, 12'b001010101111, 11};

        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset in the middle of the data bits of a frame
        din[0] = 9'h0A5;
        dv[0]  = 1'b1;
        tick();
        dv[0]  = 1'b0;
        repeat (1 + 8 + 3 * 8 + 2) tick();
        chk("data bit3 before reset", 0, ser[0], 0);
        rst = 1'b1;
        #1;
        chk("reset serial", 0, ser[0], 1);
        chk("reset busy",   0, bsy[0], 0);
        chk("reset level",  0, lvl[0], 0);
        chk("reset ready",  0, rdy[0], 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Directed frames (first one is the clean frame after reset)
        for (int v = 0; v < 6; v++) run_vec(tbl[v]);

        // Back-to-back frames on 8N1
        wait_idle();
        din[0] = 9'h055;
        dv[0]  = 1'b1;
        tick();
        e0     = cyc;
        din[0] = 9'h0AA;
        k = 0;
        while (k < 50) begin
            tick();
            k++;
            if (e_took[0]) break;
        end
        dv[0] = 1'b0;
        while (cyc < e0 + 80) tick();
        chk("b2b last stop bit", 0, ser[0], 1);
        tick();
        chk("b2b second start", 0, ser[0], 0);
        chk("b2b busy", 0, bsy[0], 1);

        // Six words with valid held: storage fills, nothing lost
        wait_idle();
        for (int i = 0; i < 6; i++) words[i] = 9'($urandom);
        idx    = 0;
        maxl   = 0;
        k      = 0;
        din[0] = words[0];
        dv[0]  = 1'b1;
        while (idx < 6 && k < 2000) begin
            tick();
            k++;
            if (int'(lvl[0]) > maxl) maxl = int'(lvl[0]);
            if (e_took[0]) begin
                idx++;
                if (idx < 6) din[0] = words[idx];
            end
        end
        dv[0] = 1'b0;
        chk("words accepted", 0, idx, 6);
        chk("max level", 0, maxl, c_cap);
        wait_idle();

        // Random traffic on all three configurations
        for (int n = 0; n < 2500; n++) begin
            for (int g = 0; g < 3; g++) begin
                dv[g]  = ($urandom_range(0, 3) == 0);
                din[g] = 9'($urandom);
            end
            tick();
        end
        dv = '0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_tx_cfg
`default_nettype wire
